// File: rtl/traffic_phase_countdown.sv
// Traffic-light phase sequencer: NS/EW lamps, a per-phase BCD seconds countdown,
// and a two-digit scan mux feeding one nibble per slot to a downstream 7-seg decoder.
module traffic_phase_countdown #(
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000,
   parameter int GREEN_S  = 25,
   parameter int YELLOW_S = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [3:0] bcd,
   output logic [1:0] an
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [3:0] GREEN_T  = 4'(GREEN_S / 10);
   localparam logic [3:0] GREEN_O  = 4'(GREEN_S % 10);
   localparam logic [3:0] YELLOW_T = 4'(YELLOW_S / 10);
   localparam logic [3:0] YELLOW_O = 4'(YELLOW_S % 10);

   typedef enum logic [1:0] {
      S_NS_G = 2'd0,
      S_NS_Y = 2'd1,
      S_EW_G = 2'd2,
      S_EW_Y = 2'd3
   } state_t;

   state_t          state_reg;
   logic [3:0]      rem_t_reg;
   logic [3:0]      rem_o_reg;
   logic [TW-1:0]   tick_cnt_reg;
   logic [SW-1:0]   scan_cnt_reg;
   logic            sel_reg;
   logic            tick;
   logic            scan_step;

   assign tick      = en && (tick_cnt_reg == TW'(TICK_DIV - 1));
   assign scan_step = (scan_cnt_reg == SW'(SCAN_DIV - 1));

   // Prescaler: frozen while en is low so a resumed phase keeps its partial second.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_reg <= '0;
      end else if (en) begin
         if (tick) tick_cnt_reg <= '0;
         else      tick_cnt_reg <= tick_cnt_reg + TW'(1);
      end
   end

   // Phase FSM and BCD countdown; a phase ends on the tick that sees 01.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_NS_G;
         rem_t_reg <= GREEN_T;
         rem_o_reg <= GREEN_O;
      end else if (tick) begin
         if (rem_t_reg == 4'd0 && rem_o_reg == 4'd1) begin
            case (state_reg)
               S_NS_G: begin
                  state_reg <= S_NS_Y;
                  rem_t_reg <= YELLOW_T;
                  rem_o_reg <= YELLOW_O;
               end
               S_NS_Y: begin
                  state_reg <= S_EW_G;
                  rem_t_reg <= GREEN_T;
                  rem_o_reg <= GREEN_O;
               end
               S_EW_G: begin
                  state_reg <= S_EW_Y;
                  rem_t_reg <= YELLOW_T;
                  rem_o_reg <= YELLOW_O;
               end
               default: begin
                  state_reg <= S_NS_G;
                  rem_t_reg <= GREEN_T;
                  rem_o_reg <= GREEN_O;
               end
            endcase
         end else if (rem_o_reg == 4'd0) begin
            rem_o_reg <= 4'd9;
            rem_t_reg <= rem_t_reg - 4'd1;
         end else begin
            rem_o_reg <= rem_o_reg - 4'd1;
         end
      end
   end

   always_comb begin
      ns_light = 3'b100;
      ew_light = 3'b100;
      case (state_reg)
         S_NS_G: ns_light = 3'b001;
         S_NS_Y: ns_light = 3'b010;
         S_EW_G: ew_light = 3'b001;
         default: ew_light = 3'b010;
      endcase
   end

   // Scan mux runs regardless of en; it samples the remaining time as it stood before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_reg <= '0;
         sel_reg      <= 1'b1;
         an           <= 2'b11;
         bcd          <= 4'hF;
      end else if (scan_step) begin
         scan_cnt_reg <= '0;
         sel_reg      <= ~sel_reg;
         if (sel_reg) begin
            an  <= 2'b10;
            bcd <= rem_o_reg;
         end else begin
            an  <= 2'b01;
            bcd <= (rem_t_reg == 4'd0) ? 4'hF : rem_t_reg;
         end
      end else begin
         scan_cnt_reg <= scan_cnt_reg + SW'(1);
      end
   end

endmodule

// File: tb/tb_traffic_phase_countdown.sv
// Randomized-enable bench for traffic_phase_countdown: a cycle-count model derives
// phase and remaining seconds arithmetically, plus literal spot checks of known points.
module tb_traffic_phase_countdown;

   localparam int TICK_DIV = 4;
   localparam int SCAN_DIV = 2;
   localparam int GREEN_S  = 12;
   localparam int YELLOW_S = 3;
   localparam int CYCLE_S  = 2 * (GREEN_S + YELLOW_S);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [2:0] ns_light, ew_light;
   logic [3:0] bcd;
   logic [1:0] an;

   int checks = 0;
   int failures = 0;

   traffic_phase_countdown #(
      .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .ns_light(ns_light), .ew_light(ew_light), .bcd(bcd), .an(an)
   );

   always #5 clk = ~clk;

   // Model state: enabled cycles and total cycles since reset release.
   int         en_cyc;
   int         cyc;
   logic [1:0] m_an;
   logic [3:0] m_bcd;

   function automatic int phase_of(input int ec);
      int pos;
      pos = (ec / TICK_DIV) % CYCLE_S;
      if (pos < GREEN_S)                     return 0;
      else if (pos < GREEN_S + YELLOW_S)     return 1;
      else if (pos < 2 * GREEN_S + YELLOW_S) return 2;
      else                                   return 3;
   endfunction

   function automatic int rem_of(input int ec);
      int pos;
      pos = (ec / TICK_DIV) % CYCLE_S;
      if (pos < GREEN_S)                     return GREEN_S - pos;
      else if (pos < GREEN_S + YELLOW_S)     return GREEN_S + YELLOW_S - pos;
      else if (pos < 2 * GREEN_S + YELLOW_S) return 2 * GREEN_S + YELLOW_S - pos;
      else                                   return CYCLE_S - pos;
   endfunction

   function automatic logic [5:0] lamps_of(input int ec);
      case (phase_of(ec))
         0:       return 6'b001_100;
         1:       return 6'b010_100;
         2:       return 6'b100_001;
         default: return 6'b100_010;
      endcase
   endfunction

   function automatic logic [3:0] tens_of(input int r);
      return (r / 10 == 0) ? 4'hF : 4'(r / 10);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_cyc <= 0;
         cyc    <= 0;
         m_an   <= 2'b11;
         m_bcd  <= 4'hF;
      end else begin
         if (en) en_cyc <= en_cyc + 1;
         cyc <= cyc + 1;
         if ((cyc + 1) % SCAN_DIV == 0) begin
            if (((cyc + 1) / SCAN_DIV) % 2 == 1) begin
               m_an  <= 2'b10;
               m_bcd <= 4'(rem_of(en_cyc) % 10);
            end else begin
               m_an  <= 2'b01;
               m_bcd <= tens_of(rem_of(en_cyc));
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus the both-directions-not-red safety rule.
   always @(negedge clk) begin
      check("model_outputs", {2'b0, ns_light, ew_light, an, bcd},
            {2'b0, lamps_of(en_cyc), m_an, m_bcd});
      check("no_conflict", {15'b0, (ns_light[2] | ew_light[2])}, 16'd1);
      $display("cyc=%0d en=%0b ns=%03b ew=%03b an=%02b bcd=%h", cyc, en, ns_light, ew_light, an, bcd);
   end

   task automatic edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_release();
      rst_n = 1'b0;
      edges(3);
      check("reset_ns", {13'b0, ns_light}, 16'h0001);
      check("reset_ew", {13'b0, ew_light}, 16'h0004);
      check("reset_an", {14'b0, an}, 16'h0003);
      check("reset_bcd", {12'b0, bcd}, 16'h000F);
      rst_n = 1'b1;
   endtask

   task automatic first_steps();
      edges(2);
      check("step1_an", {14'b0, an}, 16'h0002);
      check("step1_bcd", {12'b0, bcd}, 16'h0002);
      edges(2);
      check("step2_an", {14'b0, an}, 16'h0001);
      check("step2_bcd", {12'b0, bcd}, 16'h0001);
      check("step2_ns", {13'b0, ns_light}, 16'h0001);
   endtask

   initial begin
      @(negedge clk);
      en = 1'b1;
      reset_release();
      first_steps();
      // rem reaches 09 at the third tick: ones slot shows 9, blanked tens slot shows F.
      edges(10);
      check("rem09_ones_an", {14'b0, an}, 16'h0002);
      check("rem09_ones_bcd", {12'b0, bcd}, 16'h0009);
      edges(2);
      check("rem09_tens_an", {14'b0, an}, 16'h0001);
      check("rem09_tens_bcd", {12'b0, bcd}, 16'h000F);
      // Freeze at rem=07 for 100 clocks; display keeps scanning 7 and F.
      edges(4);
      en = 1'b0;
      edges(100);
      check("hold_ns", {13'b0, ns_light}, 16'h0001);
      check("hold_tens_an", {14'b0, an}, 16'h0001);
      check("hold_tens_bcd", {12'b0, bcd}, 16'h000F);
      edges(2);
      check("hold_ones_an", {14'b0, an}, 16'h0002);
      check("hold_ones_bcd", {12'b0, bcd}, 16'h0007);
      en = 1'b1;
      edges(20);

      // Phase boundaries with en held high.
      reset_release();
      edges(48);
      check("t48_ns", {13'b0, ns_light}, 16'h0002);
      check("t48_ew", {13'b0, ew_light}, 16'h0004);
      edges(12);
      check("t60_ns", {13'b0, ns_light}, 16'h0004);
      check("t60_ew", {13'b0, ew_light}, 16'h0001);
      edges(60);
      check("t120_ns", {13'b0, ns_light}, 16'h0001);
      check("t120_ew", {13'b0, ew_light}, 16'h0004);
      edges(2);
      check("t122_bcd", {12'b0, bcd}, 16'h0002);

      // Randomized enable pattern, checked by the per-cycle model.
      for (int i = 0; i < 1500; i++) begin
         en = ($urandom_range(0, 3) != 0);
         edges(1);
      end
      en = 1'b1;

      // Asynchronous reset in the middle of S_EW_Y, between clock edges.
      reset_release();
      edges(110);
      check("ewy_ew", {13'b0, ew_light}, 16'h0002);
      #2 rst_n = 1'b0;
      #1;
      check("async_ns", {13'b0, ns_light}, 16'h0001);
      check("async_ew", {13'b0, ew_light}, 16'h0004);
      check("async_an", {14'b0, an}, 16'h0003);
      check("async_bcd", {12'b0, bcd}, 16'h000F);
      edges(2);
      rst_n = 1'b1;
      first_steps();
      edges(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
